dcache_controller: RTL

Sequencing controller for the processor's direct-mapped data cache. It sits between the control unit's MemRead/MemWrite outputs and the cache data array / main-memory port. It keeps the tag and valid arrays, detects hits, stalls the single-cycle core on misses and writes, and runs block refills and write-through transfers over a per-word ready handshake. The policy is write-through, no-write-allocate.

---
 rtl/dcache_controller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dcache_controller.sv
// dcache_controller
// Sequencing controller for a direct-mapped, write-through, no-write-allocate
// data cache. Holds the tag/valid arrays, detects hits, stalls the core on
// read misses and on every store, and runs 4-word block refills and
// single-word write-through transfers over a per-word ready handshake.
// All outputs are combinational from state, word counter, arrays and inputs.

module dcache_controller #(
    parameter int ADDR_W = 10,
    parameter int IDX_W  = 5,
    parameter int OFF_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_read_i,
    input  logic                   mem_write_i,
    input  logic [ADDR_W-1:0]      addr_i,
    output logic                   stall_o,
    output logic                   hit_o,
    output logic                   cache_we_o,
    output logic [IDX_W+OFF_W-1:0] cache_addr_o,
    output logic                   cache_src_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    input  logic                   mem_ready_i
);

    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int LINES = 1 << IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    state_t             state_reg;
    logic [OFF_W-1:0]   word_cnt_reg;
    logic [LINES-1:0]   valid_reg;
    logic [TAG_W-1:0]   tag_mem [LINES];

    // Address fields of the current request
    logic [TAG_W-1:0]   addr_tag;
    logic [IDX_W-1:0]   addr_idx;
    logic [OFF_W-1:0]   addr_off;

    logic [TAG_W-1:0]   line_tag;
    logic               line_hit;
    logic               last_beat;
    logic               refill_done;
    logic [LINES-1:0]   line_set;

    assign addr_tag = addr_i[ADDR_W-1:IDX_W+OFF_W];
    assign addr_idx = addr_i[IDX_W+OFF_W-1:OFF_W];
    assign addr_off = addr_i[OFF_W-1:0];

    // Tag lookup is asynchronous so that a read hit completes in the same cycle
    assign line_tag = tag_mem[addr_idx];
    assign line_hit = valid_reg[addr_idx] && (line_tag == addr_tag);

    // During a refill the line is being overwritten, so never report a hit
    assign hit_o = line_hit && (state_reg != ST_REFILL);

    assign last_beat   = (word_cnt_reg == {OFF_W{1'b1}});
    assign refill_done = (state_reg == ST_REFILL) && mem_ready_i && last_beat;

    // One-hot set strobe per line; a line only becomes valid on its last refill beat
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_line_set
            assign line_set[gi] = refill_done && (addr_idx == IDX_W'(gi));
        end
    endgenerate

    // Controller state and refill word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            word_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (mem_write_i) begin
                        state_reg <= ST_WRITE;
                    end else if (mem_read_i && !line_hit) begin
                        state_reg    <= ST_REFILL;
                        word_cnt_reg <= '0;
                    end
                end
                ST_REFILL: begin
                    if (mem_ready_i) begin
                        word_cnt_reg <= word_cnt_reg + OFF_W'(1);
                        if (last_beat) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_ready_i) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Valid bits: cleared by reset, set only when a refill completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_reg | line_set;
        end
    end

    // Tag array: written together with the valid bit on the final refill beat
    always_ff @(posedge clk) begin
        if (refill_done) begin
            tag_mem[addr_idx] <= addr_tag;
        end
    end

    // Combinational outputs decoded from state, counter, hit and handshake
    always_comb begin
        stall_o      = 1'b0;
        cache_we_o   = 1'b0;
        cache_src_o  = 1'b0;
        cache_addr_o = {addr_idx, addr_off};
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = addr_i;
        case (state_reg)
            ST_IDLE: begin
                stall_o = (mem_read_i && !line_hit) || mem_write_i;
            end
            ST_REFILL: begin
                stall_o    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {addr_tag, addr_idx, word_cnt_reg};
                if (mem_ready_i) begin
                    cache_we_o   = 1'b1;
                    cache_src_o  = 1'b1;
                    cache_addr_o = {addr_idx, word_cnt_reg};
                end
            end
            ST_WRITE: begin
                stall_o   = !mem_ready_i;
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                // Write-through: update the array only if the line is present
                cache_we_o = mem_ready_i && line_hit;
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

endmodule
